// File: rtl/divsqrt_arbiter.sv
// divsqrt_arbiter
// Shares one divide/sqrt unit among numReq requesters. Only one operation is
// outstanding at a time. A round-robin pointer picks the next requester. The
// unit result is returned to the requester that owns the operation.
//
// Ports
//   clock, nReset            clock and synchronous active-low reset
//   req_valid/req_ready      per-requester handshake (ready is one-hot or zero)
//   req_sqrtOp, req_a/b,     per-requester operation; requester i occupies
//   req_roundingMode         bits [i*W +: W] (operands) and [i*3 +: 3] (mode)
//   resp_valid/resp_ready    per-requester result handshake (valid one-hot/zero)
//   resp_out, resp_flags     captured unit result, shared by all requesters
//   du_inValid/du_inReady    issue handshake towards the shared unit
//   du_sqrtOp, du_a/b,       operands presented to the unit
//   du_roundingMode
//   du_outValid, du_out,     unit result strobe (no backpressure)
//   du_exceptionFlags
//   err_spurious             sticky: unit produced a result nobody waited for
//   err_timeout              sticky: unit stayed silent for maxBusyCycles
module divsqrt_arbiter #(
    parameter int expWidth      = 11,
    parameter int sigWidth      = 53,
    parameter int numReq        = 4,
    parameter int maxBusyCycles = 127
) (
    input  logic                                  clock,
    input  logic                                  nReset,
    input  logic [numReq-1:0]                     req_valid,
    output logic [numReq-1:0]                     req_ready,
    input  logic [numReq-1:0]                     req_sqrtOp,
    input  logic [numReq*(expWidth+sigWidth)-1:0] req_a,
    input  logic [numReq*(expWidth+sigWidth)-1:0] req_b,
    input  logic [numReq*3-1:0]                   req_roundingMode,
    output logic [numReq-1:0]                     resp_valid,
    input  logic [numReq-1:0]                     resp_ready,
    output logic [expWidth+sigWidth-1:0]          resp_out,
    output logic [4:0]                            resp_flags,
    input  logic                                  du_inReady,
    output logic                                  du_inValid,
    output logic                                  du_sqrtOp,
    output logic [expWidth+sigWidth-1:0]          du_a,
    output logic [expWidth+sigWidth-1:0]          du_b,
    output logic [2:0]                            du_roundingMode,
    input  logic                                  du_outValid,
    input  logic [expWidth+sigWidth-1:0]          du_out,
    input  logic [4:0]                            du_exceptionFlags,
    output logic                                  err_spurious,
    output logic                                  err_timeout
);

    localparam int W  = expWidth + sigWidth;
    localparam int IW = (numReq > 1) ? $clog2(numReq) : 1;
    localparam int CW = $clog2(maxBusyCycles + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } stateT;

    stateT          stateR;
    logic [IW-1:0]  ptrR;
    logic [IW-1:0]  ownerR;
    logic [W-1:0]   aR;
    logic [W-1:0]   bR;
    logic           sqrtOpR;
    logic [2:0]     rmR;
    logic [CW-1:0]  busyCntR;
    logic [W-1:0]   outR;
    logic [4:0]     flagsR;
    logic           errSpuriousR;
    logic           errTimeoutR;

    logic [IW-1:0]  winnerS;
    logic           anyValidS;
    logic [IW:0]    rrSumS;
    logic [IW-1:0]  rrIdxS;
    logic           rrHitS;
    logic [W-1:0]   selAS;
    logic [W-1:0]   selBS;
    logic           selSqrtS;
    logic [2:0]     selRmS;
    logic [IW-1:0]  ptrNextS;
    logic [numReq-1:0] reqReadyS;

    // Round-robin search: first valid requester starting at ptrR, wrapping.
    always_comb begin
        winnerS   = '0;
        anyValidS = 1'b0;
        rrSumS    = '0;
        rrIdxS    = '0;
        rrHitS    = 1'b0;
        for (int k = 0; k < numReq; k++) begin
            rrSumS    = {1'b0, ptrR} + (IW+1)'(k);
            rrIdxS    = (rrSumS >= (IW+1)'(numReq)) ? IW'(rrSumS - (IW+1)'(numReq))
                                                    : IW'(rrSumS);
            rrHitS    = !anyValidS && req_valid[rrIdxS];
            winnerS   = rrHitS ? rrIdxS : winnerS;
            anyValidS = anyValidS | rrHitS;
        end
    end

    // Operand mux for the winning requester (AND-OR so no priority is implied).
    always_comb begin
        selAS    = '0;
        selBS    = '0;
        selSqrtS = 1'b0;
        selRmS   = 3'b000;
        for (int i = 0; i < numReq; i++) begin
            selAS    = selAS    | (req_a[i*W +: W] & {W{winnerS == IW'(i)}});
            selBS    = selBS    | (req_b[i*W +: W] & {W{winnerS == IW'(i)}});
            selSqrtS = selSqrtS | (req_sqrtOp[i] & (winnerS == IW'(i)));
            selRmS   = selRmS   | (req_roundingMode[i*3 +: 3] & {3{winnerS == IW'(i)}});
        end
    end

    // Pointer moves to the requester just after the winner.
    always_comb begin
        if (winnerS == IW'(numReq - 1)) begin
            ptrNextS = '0;
        end else begin
            ptrNextS = winnerS + IW'(1);
        end
    end

    // Grant is combinational so a requester is accepted in its request cycle.
    always_comb begin
        reqReadyS = '0;
        if (nReset && (stateR == IDLE) && anyValidS) begin
            reqReadyS = numReq'(1) << winnerS;
        end else begin
            reqReadyS = '0;
        end
    end

    assign req_ready       = reqReadyS;
    assign resp_valid      = (nReset && (stateR == RESP)) ? (numReq'(1) << ownerR) : '0;
    assign du_inValid      = nReset && (stateR == ISSUE);
    assign du_a            = aR;
    assign du_b            = bR;
    assign du_sqrtOp       = sqrtOpR;
    assign du_roundingMode = rmR;
    assign resp_out        = outR;
    assign resp_flags      = flagsR;
    assign err_spurious    = errSpuriousR;
    assign err_timeout     = errTimeoutR;

    // Arbiter FSM with operand/result capture, busy watchdog and error flags.
    always_ff @(posedge clock) begin
        if (!nReset) begin
            stateR       <= IDLE;
            ptrR         <= '0;
            ownerR       <= '0;
            aR           <= '0;
            bR           <= '0;
            sqrtOpR      <= 1'b0;
            rmR          <= 3'b000;
            busyCntR     <= '0;
            outR         <= '0;
            flagsR       <= 5'b00000;
            errSpuriousR <= 1'b0;
            errTimeoutR  <= 1'b0;
        end else begin
            // Only BUSY expects a result; anything else is a stray strobe.
            if (du_outValid && (stateR != BUSY)) begin
                errSpuriousR <= 1'b1;
            end
            case (stateR)
                IDLE: begin
                    if (anyValidS) begin
                        aR      <= selAS;
                        bR      <= selBS;
                        sqrtOpR <= selSqrtS;
                        rmR     <= selRmS;
                        ownerR  <= winnerS;
                        ptrR    <= ptrNextS;
                        stateR  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (du_inReady) begin
                        busyCntR <= '0;
                        stateR   <= BUSY;
                    end
                end
                BUSY: begin
                    if (busyCntR != CW'(maxBusyCycles)) begin
                        busyCntR <= busyCntR + CW'(1);
                    end
                    if (du_outValid) begin
                        outR   <= du_out;
                        flagsR <= du_exceptionFlags;
                        stateR <= RESP;
                    end else if (busyCntR >= CW'(maxBusyCycles - 1)) begin
                        // Give up on the unit; the owner never sees a result.
                        errTimeoutR <= 1'b1;
                        stateR      <= IDLE;
                    end
                end
                RESP: begin
                    if (resp_ready[ownerR]) begin
                        stateR <= IDLE;
                    end
                end
                default: begin
                    stateR <= IDLE;
                end
            endcase
        end
    end

endmodule
